// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader and its host-side models.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    LB_IDLE,
    LB_LEN_HI,
    LB_LEN_LO,
    LB_DATA,
    LB_CSUM,
    LB_DONE,
    LB_ERROR
  } lb_state_e;

  localparam int LB_LEN_BYTES  = 2;
  localparam int LB_WORD_BYTES = 4;
  localparam int LB_LEN_W      = 16;

  // A frame fits when its word count does not exceed the memory depth.
  function automatic logic lb_len_ok(input logic [LB_LEN_W-1:0] n, input int addr_w);
    return {1'b0, n} <= (17'd1 << addr_w);
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Host byte port plus instruction-memory write port and loader status.
interface imem_boot_loader_if #(parameter int ADDR_W = 8);
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_run;
  logic              busy;
  logic              boot_err;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata, core_run, busy, boot_err
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata, core_run, busy, boot_err
  );
endinterface

// File: rtl/imem_boot_loader_packer.sv
// Packs big-endian payload bytes into 32-bit words; word_vld_o pulses the cycle after the 4th byte.
module lb_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic        last_byte_o,
  output logic        word_vld_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q,   cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] word_q,  word_d;
  logic        vld_q,   vld_d;

  assign last_byte_o = (cnt_q == 2'd3);
  assign word_vld_o  = vld_q;
  assign word_o      = word_q;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    word_d  = word_q;
    vld_d   = 1'b0;
    if (clr_i) begin
      cnt_d   = 2'd0;
      shift_d = '0;
    end else if (byte_vld_i) begin
      cnt_d = cnt_q + 2'd1;
      if (last_byte_o) begin
        word_d = {shift_q, byte_i};
        vld_d  = 1'b1;
      end else begin
        shift_d = {shift_q[15:0], byte_i};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      vld_q   <= vld_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Framed byte-stream loader: LEN(2) | 4*N payload | XOR checksum; releases core_run on a clean load.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  imem_boot_loader_if.slave bus
);

  lb_state_e         state_q, state_d;
  logic [15:0]       len_q,   len_d;
  logic [15:0]       wcnt_q,  wcnt_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        csum_q,  csum_d;

  logic        loading, accept, last_byte, word_vld;
  logic [31:0] word;
  logic [15:0] len_rx;

  assign loading = (state_q == LB_LEN_HI) || (state_q == LB_LEN_LO) ||
                   (state_q == LB_DATA)   || (state_q == LB_CSUM);
  // start owns the cycle: the byte presented alongside it is refused.
  assign accept  = bus.in_valid && loading && !bus.start;
  assign len_rx  = {len_q[15:8], bus.in_data};

  lb_word_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (bus.start),
    .byte_vld_i  (accept && (state_q == LB_DATA)),
    .byte_i      (bus.in_data),
    .last_byte_o (last_byte),
    .word_vld_o  (word_vld),
    .word_o      (word)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    waddr_d = waddr_q;
    csum_d  = csum_q;
    if (word_vld) waddr_d = waddr_q + 1'b1;
    if (bus.start) begin
      state_d = LB_LEN_HI;
      len_d   = '0;
      wcnt_d  = '0;
      waddr_d = '0;
      csum_d  = '0;
    end else if (accept) begin
      csum_d = csum_q ^ bus.in_data;
      unique case (state_q)
        LB_LEN_HI: begin
          len_d   = {bus.in_data, 8'h00};
          state_d = LB_LEN_LO;
        end
        LB_LEN_LO: begin
          len_d = len_rx;
          if (!lb_len_ok(len_rx, ADDR_W)) state_d = LB_ERROR;
          else if (len_rx == 16'd0)       state_d = LB_CSUM;
          else                            state_d = LB_DATA;
        end
        LB_DATA: begin
          if (last_byte) begin
            wcnt_d = wcnt_q + 16'd1;
            if (wcnt_q == len_q - 16'd1) state_d = LB_CSUM;
          end
        end
        LB_CSUM: state_d = ((csum_q ^ bus.in_data) == 8'h00) ? LB_DONE : LB_ERROR;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LB_IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      waddr_q <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      waddr_q <= waddr_d;
      csum_q  <= csum_d;
    end
  end

  assign bus.in_ready   = loading && !bus.start;
  assign bus.busy       = loading;
  assign bus.core_run   = (state_q == LB_DONE);
  assign bus.boot_err   = (state_q == LB_ERROR);
  assign bus.imem_we    = word_vld;
  assign bus.imem_addr  = waddr_q;
  assign bus.imem_wdata = word;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Random and directed frames checked every cycle against a frame-level host model.
module tb_imem_boot_loader;
  import imem_boot_loader_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();
  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: position in the frame, word count, running XOR, outcome.
  typedef enum {M_IDLE, M_LOAD, M_OK, M_BAD} mmode_e;
  mmode_e      m_mode;
  int          m_pos, m_n, m_waddr;
  logic [7:0]  m_x, m_b;
  logic [31:0] m_acc, m_wdata;
  logic        m_we;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] dut_mem [DEPTH];
  int          n_writes = 0;

  task automatic model_reset();
    m_mode = M_IDLE; m_pos = 0; m_n = 0; m_x = 0; m_acc = 0; m_we = 0; m_waddr = 0; m_wdata = 0;
  endtask

  task automatic model_step();
    m_we = 1'b0;
    if (bus.start) begin
      m_mode = M_LOAD; m_pos = 0; m_x = 0;
    end else if (m_mode == M_LOAD && bus.in_valid) begin
      m_b = bus.in_data;
      if (m_pos == 0) begin
        m_n = int'(m_b) * 256; m_x ^= m_b; m_pos = 1;
      end else if (m_pos == 1) begin
        m_n += int'(m_b); m_x ^= m_b; m_pos = 2;
        if (m_n > DEPTH) m_mode = M_BAD;
      end else if (m_pos < 2 + 4 * m_n) begin
        m_x ^= m_b;
        m_acc = {m_acc[23:0], m_b};
        if ((m_pos - 2) % 4 == 3) begin
          m_we = 1'b1; m_waddr = (m_pos - 2) / 4; m_wdata = m_acc;
          ref_mem[m_waddr] = m_acc;
        end
        m_pos++;
      end else begin
        m_mode = ((m_x ^ m_b) == 8'h00) ? M_OK : M_BAD;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  always @(posedge clk)
    if (rst_n && bus.imem_we) begin
      dut_mem[bus.imem_addr] <= bus.imem_wdata;
      n_writes <= n_writes + 1;
    end

  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", bus.in_ready, (m_mode == M_LOAD) && !bus.start);
      chk("busy",     bus.busy,     m_mode == M_LOAD);
      chk("core_run", bus.core_run, m_mode == M_OK);
      chk("boot_err", bus.boot_err, m_mode == M_BAD);
      chk("imem_we",  bus.imem_we,  m_we);
      if (m_we) begin
        chk("imem_addr",  bus.imem_addr,  m_waddr);
        chk("imem_wdata", bus.imem_wdata, m_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b, input int maxgap);
    int g;
    g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    repeat (g) begin bus.in_valid = 1'b0; bus.in_data = 8'($urandom); tick(); end
    bus.in_valid = 1'b1; bus.in_data = b; tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
  endtask

  logic [31:0] wq [$];

  // Sends wq as a frame; bad flips one checksum bit.
  task automatic send_frame(input bit bad, input int gap);
    logic [7:0]  x = 8'h00;
    logic [7:0]  b;
    logic [15:0] n;
    logic [31:0] w;
    n = 16'(wq.size());
    b = n[15:8]; x ^= b; send(b, gap);
    b = n[7:0];  x ^= b; send(b, gap);
    foreach (wq[i]) begin
      w = wq[i];
      for (int k = 3; k >= 0; k--) begin b = w[8*k +: 8]; x ^= b; send(b, gap); end
    end
    if (bad) x ^= 8'h01 << $urandom_range(7, 0);
    send(x, gap);
  endtask

  logic [7:0] case1 [11] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                             8'h20, 8'h09, 8'h00, 8'h0A, 8'h0C};
  int wbase;

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    for (int i = 0; i < DEPTH; i++) dut_mem[i] = 32'hDEADBEEF;
    #1;
    chk("reset in_ready", bus.in_ready, 0);
    chk("reset imem_we",  bus.imem_we,  0);
    chk("reset addr",     bus.imem_addr, 0);
    chk("reset wdata",    bus.imem_wdata, 0);
    chk("reset core_run", bus.core_run, 0);
    chk("reset busy",     bus.busy,     0);
    chk("reset boot_err", bus.boot_err, 0);
    tick(); tick(); rst_n = 1'b1; tick();

    // Case 1: XOR of the ten frame bytes is 0x0C.
    pulse_start();
    wbase = n_writes;
    for (int i = 0; i < 11; i++) send(case1[i], 0);
    chk("c1 core_run", bus.core_run, 1);
    chk("c1 boot_err", bus.boot_err, 0);
    chk("c1 mem0", dut_mem[0], 32'h20080005);
    chk("c1 mem1", dut_mem[1], 32'h2009000A);
    chk("c1 writes", n_writes - wbase, 2);

    // Empty frame.
    pulse_start();
    wbase = n_writes;
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    chk("c2 core_run", bus.core_run, 1);
    chk("c2 writes", n_writes - wbase, 0);

    // Case 1 with a wrong checksum.
    pulse_start();
    wbase = n_writes;
    for (int i = 0; i < 10; i++) send(case1[i], 0);
    send(8'h0B, 0);
    chk("c3 boot_err", bus.boot_err, 1);
    chk("c3 core_run", bus.core_run, 0);
    chk("c3 in_ready", bus.in_ready, 0);
    chk("c3 writes", n_writes - wbase, 2);

    // Oversize length 257.
    pulse_start();
    wbase = n_writes;
    send(8'h01, 0); send(8'h01, 0);
    chk("c4 boot_err", bus.boot_err, 1);
    repeat (6) send(8'($urandom), 1);
    chk("c4 writes", n_writes - wbase, 0);
    chk("c4 still err", bus.boot_err, 1);

    // Interrupted load mid-word 1, then a clean load of case 1 with gaps.
    pulse_start();
    send(8'h00, 2); send(8'h02, 2);
    send(8'h11, 2); send(8'h22, 2); send(8'h33, 2); send(8'h44, 2);
    send(8'h55, 2); send(8'h66, 2);
    tick();
    pulse_start();
    wq = {32'h20080005, 32'h2009000A};
    send_frame(1'b0, 3);
    chk("c5 core_run", bus.core_run, 1);
    chk("c5 mem0", dut_mem[0], 32'h20080005);
    chk("c5 mem1", dut_mem[1], 32'h2009000A);

    // Random frames, some with a corrupted checksum.
    for (int t = 0; t < 8; t++) begin
      bit bad;
      int n;
      n   = int'($urandom_range(6, 0));
      bad = ($urandom_range(3, 0) == 0);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      pulse_start();
      send_frame(bad, 3);
      tick();
      chk("rnd core_run", bus.core_run, !bad);
      chk("rnd boot_err", bus.boot_err, bad);
      for (int i = 0; i < n; i++) chk("rnd mem", dut_mem[i], ref_mem[i]);
    end

    // N == DEPTH fills the whole memory.
    wq.delete();
    for (int i = 0; i < DEPTH; i++) wq.push_back($urandom);
    pulse_start();
    wbase = n_writes;
    send_frame(1'b0, 0);
    chk("full core_run", bus.core_run, 1);
    chk("full writes", n_writes - wbase, DEPTH);
    chk("full mem0",    dut_mem[0],       wq[0]);
    chk("full memlast", dut_mem[DEPTH-1], wq[DEPTH-1]);

    // Asynchronous reset during DATA.
    pulse_start();
    send(8'h00, 0); send(8'h04, 0);
    repeat (5) send(8'($urandom), 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst busy",     bus.busy,     0);
    chk("arst in_ready", bus.in_ready, 0);
    chk("arst imem_we",  bus.imem_we,  0);
    chk("arst addr",     bus.imem_addr, 0);
    chk("arst wdata",    bus.imem_wdata, 0);
    chk("arst core_run", bus.core_run, 0);
    chk("arst boot_err", bus.boot_err, 0);
    #2;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    chk("idle busy", bus.busy, 0);

    // start with a byte in the same cycle: the byte must not open the frame.
    bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h00;
    #2;
    chk("start+valid in_ready", bus.in_ready, 0);
    tick();
    bus.start = 1'b0; bus.in_valid = 1'b0;
    wq = {32'hAABBCCDD};
    send_frame(1'b0, 1);
    chk("c6 core_run", bus.core_run, 1);
    chk("c6 mem0", dut_mem[0], 32'hAABBCCDD);

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
